network_peer: RTL and testbench

Remote network endpoint that speaks the tagged-word protocol on the ASP network interface from the far side. It receives `{data, tag}` words, recomputes and checks the tag with the shared secret key, and returns a one-cycle ACK only on a match. It also originates tagged words toward the ASP and waits for the ASP's ACK, with timeout and bounded retry. It is used as the network-side counterpart in system integration and as the bench responder for ASP verification.

---
 rtl/network_peer.sv | 161 ++++++++++++++++
 tb/tb_network_peer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_peer.sv
// rtl/network_peer.sv - tagged-word network endpoint: verifies received words and ACKs them,
// sends local words and waits for the far-side ACK with timeout and bounded retry
module network_peer #(
   parameter int data_size   = 32,
   parameter int tag_size    = 8,
   parameter int ack_timeout = 16,
   parameter int max_retry   = 3
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [15:0]                   i_secret_key,
   input  logic                          i_network_data_ready_in,
   input  logic [data_size+tag_size-1:0] i_network_data_tag_in,
   input  logic                          i_network_ACK_in,
   output logic                          o_network_data_ready_out,
   output logic [data_size+tag_size-1:0] o_network_data_tag_out,
   output logic                          o_network_ACK_out,
   input  logic                          i_tx_valid,
   input  logic [data_size-1:0]          i_tx_data,
   output logic                          o_tx_ready,
   output logic                          o_tx_done,
   output logic                          o_tx_fail,
   output logic                          o_rx_valid,
   output logic [data_size-1:0]          o_rx_data,
   output logic                          o_auth_error,
   output logic [15:0]                   o_auth_error_count
);

   localparam int WORD_W  = data_size + tag_size;
   localparam int TIMER_W = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
   localparam int RETRY_W = (max_retry > 0) ? $clog2(max_retry + 1) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ack_timeout - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(max_retry);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, DONE, FAIL} state_t;

   // Fold every tag-sized slice of the payload and of the key together.
   function automatic logic [tag_size-1:0] f_tag(input logic [data_size-1:0] d,
                                                 input logic [15:0] k);
      logic [tag_size-1:0] t;
      t = '0;
      for (int i = 0; i < data_size / tag_size; i++) t ^= d[i*tag_size +: tag_size];
      for (int i = 0; i < 16 / tag_size; i++) t ^= k[i*tag_size +: tag_size];
      return t;
   endfunction

   logic                 r_in_valid;
   logic [WORD_W-1:0]    r_in_word;
   logic                 w_rx_match;
   logic                 r_ack;
   logic                 r_rx_valid;
   logic [data_size-1:0] r_rx_data;
   logic                 r_auth_error;
   logic [15:0]          r_auth_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_in_valid <= 1'b0;
         r_in_word  <= '0;
      end else begin
         r_in_valid <= i_network_data_ready_in;
         if (i_network_data_ready_in) r_in_word <= i_network_data_tag_in;
      end
   end

   assign w_rx_match = (f_tag(r_in_word[WORD_W-1:tag_size], i_secret_key)
                        == r_in_word[tag_size-1:0]);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ack        <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_data    <= '0;
         r_auth_error <= 1'b0;
         r_auth_count <= '0;
      end else begin
         r_ack        <= r_in_valid & w_rx_match;
         r_rx_valid   <= r_in_valid & w_rx_match;
         r_auth_error <= r_in_valid & ~w_rx_match;
         if (r_in_valid & w_rx_match) r_rx_data <= r_in_word[WORD_W-1:tag_size];
         if (r_in_valid & ~w_rx_match & (r_auth_count != 16'hFFFF))
            r_auth_count <= r_auth_count + 16'd1;
      end
   end

   assign o_network_ACK_out  = r_ack;
   assign o_rx_valid         = r_rx_valid;
   assign o_rx_data          = r_rx_data;
   assign o_auth_error       = r_auth_error;
   assign o_auth_error_count = r_auth_count;

   state_t               r_state;
   state_t               w_next_state;
   logic [WORD_W-1:0]    r_tx_word;
   logic [TIMER_W-1:0]   r_timer;
   logic [RETRY_W-1:0]   r_retry;
   logic                 w_timeout;

   assign w_timeout = (r_timer == TIMER_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state             = r_state;
      o_tx_ready               = 1'b0;
      o_network_data_ready_out = 1'b0;
      o_tx_done                = 1'b0;
      o_tx_fail                = 1'b0;
      case (r_state)
         IDLE: begin
            o_tx_ready = 1'b1;
            if (i_tx_valid) w_next_state = SEND;
         end
         SEND: begin
            o_network_data_ready_out = 1'b1;
            w_next_state             = WAIT_ACK;
         end
         WAIT_ACK: begin
            // ACK wins over a timeout landing in the same cycle
            if (i_network_ACK_in)         w_next_state = DONE;
            else if (w_timeout)           w_next_state = (r_retry < RETRY_MAX) ? SEND : FAIL;
         end
         DONE: begin
            o_tx_done    = 1'b1;
            w_next_state = IDLE;
         end
         FAIL: begin
            o_tx_fail    = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tx_word <= '0;
         r_timer   <= '0;
         r_retry   <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_tx_valid) begin
               r_tx_word <= {i_tx_data, f_tag(i_tx_data, i_secret_key)};
               r_retry   <= '0;
            end
            SEND: r_timer <= '0;
            WAIT_ACK: if (!i_network_ACK_in) begin
               if (!w_timeout)              r_timer <= r_timer + 1'b1;
               else if (r_retry < RETRY_MAX) r_retry <= r_retry + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_network_data_tag_out = r_tx_word;

endmodule

// File: tb/tb_network_peer.sv
// tb/tb_network_peer.sv - scoreboard bench for network_peer with a behavioural reference model
`timescale 1ns/1ps
module tb_network_peer;
   localparam int DW = 32, TW = 8, TO = 16, MR = 3, WW = 40;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   key = 16'hA5C3;
   logic          nd_in = 1'b0;
   logic [WW-1:0] ndt_in = '0;
   logic          ack_in = 1'b0;
   logic          nd_out, ack_out;
   logic [WW-1:0] ndt_out;
   logic          tx_valid = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_ready, tx_done, tx_fail, rx_valid, auth_error;
   logic [DW-1:0] rx_data;
   logic [15:0]   auth_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct { int cyc; logic good; logic [31:0] data; logic [15:0] cnt; } rx_exp_t;
   typedef struct { int cyc; int kind; logic [WW-1:0] word; } tx_exp_t;
   rx_exp_t rxq[$];
   tx_exp_t txq[$];
   logic [31:0] m_rx_data = '0;
   int          m_cnt = 0;

   network_peer dut (
      .i_clk(clk), .i_reset(reset), .i_secret_key(key),
      .i_network_data_ready_in(nd_in), .i_network_data_tag_in(ndt_in),
      .i_network_ACK_in(ack_in), .o_network_data_ready_out(nd_out),
      .o_network_data_tag_out(ndt_out), .o_network_ACK_out(ack_out),
      .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
      .o_tx_done(tx_done), .o_tx_fail(tx_fail), .o_rx_valid(rx_valid),
      .o_rx_data(rx_data), .o_auth_error(auth_error), .o_auth_error_count(auth_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #950000;
      $display("FAIL watchdog: cycle %0d reached, run expected to end earlier", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] model_tag(input logic [31:0] d, input logic [15:0] k);
      return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ k[15:8] ^ k[7:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rx(input logic [31:0] d, input logic [7:0] tag);
      logic good;
      good   = (tag == model_tag(d, key));
      nd_in  = 1'b1;
      ndt_in = {d, tag};
      if (good) m_rx_data = d;
      else if (m_cnt < 65535) m_cnt++;
      rxq.push_back('{cyc + 2, good, m_rx_data, 16'(m_cnt)});
      step(1);
      nd_in = 1'b0;
   endtask

   function automatic logic [7:0] bad_tag(input logic [31:0] d);
      return model_tag(d, key) ^ 8'($urandom_range(1, 255));
   endfunction

   task automatic do_tx(input logic [31:0] d, input int ack_send, input int ack_delay);
      int c, s, ack_cyc, end_cyc;
      logic stop;
      logic [WW-1:0] w;
      check("tx_ready_idle", 64'(tx_ready), 64'(1));
      c = cyc;
      w = {d, model_tag(d, key)};
      ack_cyc = -1;
      end_cyc = c + 1 + (MR + 1) * (TO + 1);
      stop = 1'b0;
      for (int k = 0; k <= MR && !stop; k++) begin
         s = c + 1 + k * (TO + 1);
         txq.push_back('{s, 0, w});
         if (k == ack_send) begin
            ack_cyc = s + ack_delay;
            end_cyc = ack_cyc + 1;
            stop    = 1'b1;
         end
      end
      txq.push_back('{end_cyc, (ack_cyc >= 0) ? 1 : 2, w});
      tx_valid = 1'b1;
      tx_data  = d;
      step(1);
      tx_valid = 1'b0;
      check("tx_ready_busy", 64'(tx_ready), 64'(0));
      check("tx_word_send_cycle", 64'(ndt_out), 64'(w));
      if (ack_cyc >= 0) begin
         while (cyc < ack_cyc) step(1);
         ack_in = 1'b1;
         step(1);
         ack_in = 1'b0;
      end
      while (cyc <= end_cyc) step(1);
      check("tx_ready_after", 64'(tx_ready), 64'(1));
   endtask

   task automatic tx_event(input int kind);
      tx_exp_t e;
      if (txq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL tx_unexpected: kind %0d at cycle %0d, nothing expected", kind, cyc);
      end else begin
         e = txq.pop_front();
         check("tx_kind", 64'(kind), 64'(e.kind));
         check("tx_cycle", 64'(cyc), 64'(e.cyc));
         if (kind == 0) check("tx_word", 64'(ndt_out), 64'(e.word));
      end
   endtask

   rx_exp_t re;
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         while (rxq.size() > 0 && rxq[0].cyc < cyc) begin
            re = rxq.pop_front();
            total++;
            bad++;
            $display("FAIL rx_missing: no response at cycle %0d for expected cycle %0d", cyc, re.cyc);
         end
         if (ack_out === 1'b1 || rx_valid === 1'b1 || auth_error === 1'b1) begin
            if (rxq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected: ack=%0b valid=%0b err=%0b at cycle %0d",
                        ack_out, rx_valid, auth_error, cyc);
            end else begin
               re = rxq.pop_front();
               check("rx_cycle", 64'(cyc), 64'(re.cyc));
               check("rx_ack", 64'(ack_out), 64'(re.good));
               check("rx_valid", 64'(rx_valid), 64'(re.good));
               check("rx_auth_error", 64'(auth_error), 64'(!re.good));
               check("rx_data", 64'(rx_data), 64'(re.data));
               check("rx_count", 64'(auth_cnt), 64'(re.cnt));
            end
         end
         while (txq.size() > 0 && txq[0].cyc < cyc) begin
            void'(txq.pop_front());
            total++;
            bad++;
            $display("FAIL tx_missing: expected event not seen by cycle %0d", cyc);
         end
         if (nd_out === 1'b1)  tx_event(0);
         if (tx_done === 1'b1) tx_event(1);
         if (tx_fail === 1'b1) tx_event(2);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_ready"}, 64'(tx_ready), 64'(1));
      check({tag, "_nd_out"}, 64'(nd_out), 64'(0));
      check({tag, "_ndt_out"}, 64'(ndt_out), 64'(0));
      check({tag, "_ack_out"}, 64'(ack_out), 64'(0));
      check({tag, "_tx_done"}, 64'(tx_done), 64'(0));
      check({tag, "_tx_fail"}, 64'(tx_fail), 64'(0));
      check({tag, "_rx_valid"}, 64'(rx_valid), 64'(0));
      check({tag, "_rx_data"}, 64'(rx_data), 64'(0));
      check({tag, "_auth_error"}, 64'(auth_error), 64'(0));
      check({tag, "_auth_count"}, 64'(auth_cnt), 64'(0));
   endtask

   initial begin
      logic [31:0] d;
      int c;
      step(3);
      reset = 1'b0;
      check_reset_outputs("reset");

      send_rx(32'h12345678, 8'h6E);
      step(4);
      check("rx_example_data", 64'(rx_data), 64'h12345678);
      check("rx_example_count", 64'(auth_cnt), 64'(0));
      send_rx(32'h12345678, 8'h6F);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         send_rx(d, model_tag(d, key));
      end
      step(4);
      check("rx_bad_count", 64'(auth_cnt), 64'(1));

      do_tx(32'h12345678, 0, 5);
      check("tx_example_word", 64'(ndt_out), 64'h12345678_6E);
      do_tx($urandom, MR + 1, 0);
      do_tx($urandom, MR, TO);
      do_tx($urandom, 1, TO);
      do_tx($urandom, 0, 1);

      // reset in the middle of WAIT_ACK: only the first send is ever seen
      d = $urandom;
      c = cyc;
      txq.push_back('{c + 1, 0, {d, model_tag(d, key)}});
      tx_valid = 1'b1;
      tx_data  = d;
      step(1);
      tx_valid = 1'b0;
      step(3);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      m_rx_data = '0;
      m_cnt     = 0;
      check_reset_outputs("midreset");
      step(5);
      ack_in = 1'b1;
      step(1);
      ack_in = 1'b0;
      step(TO * 6);
      check("stray_ack_idle", 64'(tx_ready), 64'(1));

      key = 16'($urandom);
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               d = $urandom;
               if ($urandom_range(0, 3) == 0) step(1);
               else if ($urandom_range(0, 2) == 0) send_rx(d, bad_tag(d));
               else send_rx(d, model_tag(d, key));
            end
         end
         begin
            for (int i = 0; i < 12; i++)
               do_tx($urandom, $urandom_range(0, MR + 1), $urandom_range(1, TO));
         end
      join
      step(4);

      for (int i = 0; i < 65537; i++) begin
         d = $urandom;
         send_rx(d, bad_tag(d));
      end
      step(4);
      check("auth_count_saturated", 64'(auth_cnt), 64'hFFFF);
      check("rx_queue_drained", 64'(rxq.size()), 64'(0));
      check("tx_queue_drained", 64'(txq.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
